// File: rtl/dmem_pkg.sv
// dmem_pkg: state encoding and fault-check constants shared by the data memory responder.
package dmem_pkg;
   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
   localparam int WORD_OFF_W = 2;
   localparam int CNT_W = 4;
   function automatic logic is_fault(input logic [31:0] addr, input int unsigned depth);
      return (addr[WORD_OFF_W-1:0] != '0) || ({{WORD_OFF_W{1'b0}}, addr[31:WORD_OFF_W]} >= depth);
   endfunction
endpackage

// File: rtl/data_mem_responder_if.sv
// data_mem_responder_if: initiator request/response bus of the data memory responder.
interface data_mem_responder_if;
   logic        Req;
   logic        Write;
   logic [31:0] Addr;
   logic [31:0] WData;
   logic [3:0]  ByteEn;
   logic        Ready;
   logic [31:0] RData;
   logic        Error;
   modport master (output Req, Write, Addr, WData, ByteEn, input Ready, RData, Error);
   modport slave (input Req, Write, Addr, WData, ByteEn, output Ready, RData, Error);
endinterface

// File: rtl/dmem_array.sv
// dmem_array: word storage with one byte-enabled write port and one combinational read port.
module dmem_array #(
   parameter int DEPTH = 256,
   parameter int AW = 8
) (
   input  logic          i_clk,
   input  logic          i_we,
   input  logic [3:0]    i_be,
   input  logic [AW-1:0] i_waddr,
   input  logic [31:0]   i_wdata,
   input  logic [AW-1:0] i_raddr,
   output logic [31:0]   o_rdata
);
   logic [31:0] r_mem [DEPTH];
   always_ff @(posedge i_clk)
      for (int b = 0; b < 4; b++)
         if (i_we && i_be[b]) r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
   assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: fixed-latency word memory responder with byte-enabled stores and fault detection.
module data_mem_responder
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH = 256,
   parameter int unsigned LATENCY = 2
) (
   input  logic Clk,
   input  logic Reset,
   data_mem_responder_if.slave bus
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   state_t r_state, w_next;
   logic [CNT_W-1:0] r_cnt, w_cnt;
   logic r_write, r_ready, r_error;
   logic [31:0] r_addr, r_wdata, r_rdata;
   logic [3:0] r_be;
   logic w_idle, w_write, w_fault, w_go, w_we;
   logic [31:0] w_addr, w_wdata, w_rword;
   logic [3:0] w_be;
   // In IDLE the live bus is used so a zero-latency access can commit on its capture edge.
   assign w_idle  = r_state == IDLE;
   assign w_write = w_idle ? bus.Write  : r_write;
   assign w_addr  = w_idle ? bus.Addr   : r_addr;
   assign w_wdata = w_idle ? bus.WData  : r_wdata;
   assign w_be    = w_idle ? bus.ByteEn : r_be;
   assign w_fault = is_fault(w_addr, DEPTH);
   always_comb begin
      w_next = r_state == IDLE ? (bus.Req ? (LATENCY == 0 ? RESP : WAIT) : IDLE) :
               r_state == WAIT ? (r_cnt == CNT_W'(LATENCY - 1) ? RESP : WAIT) : IDLE;
      w_cnt  = (r_state == WAIT && w_next == WAIT) ? r_cnt + CNT_W'(1) : '0;
   end
   assign w_go = w_next == RESP;
   assign w_we = w_go & w_write & ~w_fault & ~Reset;
   always_ff @(posedge Clk or posedge Reset)
      if (Reset) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_ready <= 1'b0;
         r_error <= 1'b0;
         r_rdata <= '0;
         r_write <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_be    <= '0;
      end else begin
         r_state <= w_next;
         r_cnt   <= w_cnt;
         r_ready <= w_go;
         r_error <= w_go & w_fault;
         r_rdata <= (w_go & ~w_write & ~w_fault) ? w_rword : '0;
         if (w_idle && bus.Req) begin
            r_write <= bus.Write;
            r_addr  <= bus.Addr;
            r_wdata <= bus.WData;
            r_be    <= bus.ByteEn;
         end
      end
   dmem_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
      .i_clk  (Clk),
      .i_we   (w_we),
      .i_be   (w_be),
      .i_waddr(w_addr[AW+1:2]),
      .i_wdata(w_wdata),
      .i_raddr(w_addr[AW+1:2]),
      .o_rdata(w_rword)
   );
   assign bus.Ready = r_ready;
   assign bus.Error = r_error;
   assign bus.RData = r_rdata;
endmodule
